seat_sprite_scheduler: RTL and testbench

- Shares one 30x30 occupant sprite ROM across the 8 seat windows of the seating graphic (2 rows x 4 columns).
- Sequences which seats are shown as occupied: fill, clear or load a mask, with changes applied only at frame boundaries.
- Per pixel, finds the occupied seat window under (hCount, vCount) and drives the shared ROM row/col address. Emits a hit flag aligned to the ROM's 1-cycle read latency.
- Sits between the VGA timing counters and the sprite ROM / RGB mux.

---
 rtl/seat_sprite_scheduler_pkg.sv | 63 ++++++
 rtl/seat_window_decode.sv | 61 ++++++
 rtl/seat_sprite_scheduler.sv | 152 +++++++++++++++
 tb/tb_seat_sprite_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seat_sprite_scheduler_pkg.sv
// Shared definitions for the seat sprite scheduler and the seats renderer:
// command/state encodings, default seat geometry, VGA frame-end timing and
// small occupancy-mask helpers.
package seat_sprite_scheduler_pkg;

  localparam int NUM_SEATS = 8;
  localparam int SEAT_COLS = 4;

  // Default seat geometry (pixels)
  localparam int X0_DEF      = 450;
  localparam int Y0_DEF      = 360;
  localparam int SEAT_W_DEF  = 40;
  localparam int SEAT_H_DEF  = 40;
  localparam int SEAT_SP_DEF = 15;
  localparam int ROW_GAP_DEF = 15;
  localparam int SPR_W_DEF   = 30;
  localparam int SPR_H_DEF   = 30;

  // Last counter values of a 640x480 VGA frame
  localparam int H_LAST_DEF = 799;
  localparam int V_LAST_DEF = 524;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_FILL  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_LOAD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CLEAR,
    S_LOAD
  } state_e;

  typedef struct packed {
    logic                 valid;
    cmd_op_e              op;
    logic [NUM_SEATS-1:0] mask;
  } cmd_req_t;

  // m + 1 flips the lowest clear bit to 1 and zeroes the ones below it;
  // OR-ing with m restores those lower ones.
  function automatic logic [NUM_SEATS-1:0] set_lowest_clear(input logic [NUM_SEATS-1:0] m);
    return m | (m + 1'b1);
  endfunction

  function automatic logic [NUM_SEATS-1:0] clear_highest_set(input logic [NUM_SEATS-1:0] m);
    logic [NUM_SEATS-1:0] r;
    logic                 done;
    r    = m;
    done = 1'b0;
    for (int i = NUM_SEATS-1; i >= 0; i--) begin
      if (!done && m[i]) begin
        r[i] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seat_window_decode.sv
// Combinational seat-window decode.
//   hCount, vCount : current pixel
//   occupied       : committed occupancy mask (bit i = seat i)
//   any_hit        : pixel lies inside an occupied seat's sprite window
//   winner         : lowest-index hit seat (0 when no hit)
//   rom_row/rom_col: sprite-relative offset of the winner (0 when no hit)
module seat_window_decode
  import seat_sprite_scheduler_pkg::*;
#(
  parameter int X0      = X0_DEF,
  parameter int Y0      = Y0_DEF,
  parameter int SEAT_W  = SEAT_W_DEF,
  parameter int SEAT_H  = SEAT_H_DEF,
  parameter int SEAT_SP = SEAT_SP_DEF,
  parameter int ROW_GAP = ROW_GAP_DEF,
  parameter int SPR_W   = SPR_W_DEF,
  parameter int SPR_H   = SPR_H_DEF
) (
  input  logic [9:0]           hCount,
  input  logic [9:0]           vCount,
  input  logic [NUM_SEATS-1:0] occupied,
  output logic                 any_hit,
  output logic [2:0]           winner,
  output logic [4:0]           rom_row,
  output logic [4:0]           rom_col
);

  logic [NUM_SEATS-1:0]      hit;
  logic [NUM_SEATS-1:0][4:0] row_off;
  logic [NUM_SEATS-1:0][4:0] col_off;

  for (genvar i = 0; i < NUM_SEATS; i++) begin : g_seat
    localparam int WX = X0 + (i % SEAT_COLS) * (SEAT_W + SEAT_SP) + (SEAT_W - SPR_W) / 2;
    localparam int WY = Y0 + (i / SEAT_COLS) * (SEAT_H + ROW_GAP) + (SEAT_H - SPR_H) / 2;
    logic [10:0] dx, dy;
    // Pixels left of / above the window wrap to large unsigned values,
    // so a single upper-bound compare covers both edges.
    assign dx         = {1'b0, hCount} - 11'(WX);
    assign dy         = {1'b0, vCount} - 11'(WY);
    assign hit[i]     = occupied[i] & (dx < 11'(SPR_W)) & (dy < 11'(SPR_H));
    assign col_off[i] = dx[4:0];
    assign row_off[i] = dy[4:0];
  end

  // Scan high to low so the lowest hitting index is the last writer.
  always_comb begin
    any_hit = 1'b0;
    winner  = '0;
    rom_row = '0;
    rom_col = '0;
    for (int i = NUM_SEATS-1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        winner  = 3'(i);
        rom_row = row_off[i];
        rom_col = col_off[i];
      end
    end
  end

endmodule

// File: rtl/seat_sprite_scheduler.sv
// Seat sprite scheduler: shares one sprite ROM across 8 seat windows and
// sequences seat occupancy (fill / clear / load) at frame boundaries.
//   ClkPort, rst      : pixel clock, async active-low reset
//   hCount/vCount     : VGA counters; bright = visible area
//   cmd_valid/op/mask : command request; cmd_ready high only in IDLE
//   rom_row/rom_col   : combinational sprite ROM address
//   sprite_on_d       : registered hit, aligned with ROM read data
//   seat_idx_d        : registered winning seat index
//   occupied          : committed occupancy; busy = FSM not IDLE
//   frame_tick        : 1-cycle pulse after the last pixel of a frame
module seat_sprite_scheduler
  import seat_sprite_scheduler_pkg::*;
#(
  parameter int X0          = X0_DEF,
  parameter int Y0          = Y0_DEF,
  parameter int SEAT_W      = SEAT_W_DEF,
  parameter int SEAT_H      = SEAT_H_DEF,
  parameter int SEAT_SP     = SEAT_SP_DEF,
  parameter int ROW_GAP     = ROW_GAP_DEF,
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int H_LAST      = H_LAST_DEF,
  parameter int V_LAST      = V_LAST_DEF,
  parameter int FILL_PERIOD = 30
) (
  input  logic                 ClkPort,
  input  logic                 rst,
  input  logic [9:0]           hCount,
  input  logic [9:0]           vCount,
  input  logic                 bright,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [NUM_SEATS-1:0] cmd_mask,
  output logic                 cmd_ready,
  output logic [4:0]           rom_row,
  output logic [4:0]           rom_col,
  output logic                 sprite_on_d,
  output logic [2:0]           seat_idx_d,
  output logic [NUM_SEATS-1:0] occupied,
  output logic                 busy,
  output logic                 frame_tick
);

  // One register stage to match the synchronous ROM read.
  localparam int         STAGES    = 1;
  localparam logic [7:0] STEP_LAST = 8'(FILL_PERIOD - 1);

  state_e               state, state_n;
  logic [NUM_SEATS-1:0] occ_n, pending, pend_n;
  logic [7:0]           fcnt, fcnt_n;
  logic                 any_hit;
  logic [2:0]           winner;
  logic [STAGES:0]      vld_pipe;
  logic                 frame_end;
  cmd_req_t             req;

  assign req = '{valid: cmd_valid, op: cmd_op_e'(cmd_op), mask: cmd_mask};

  seat_window_decode #(
    .X0(X0), .Y0(Y0), .SEAT_W(SEAT_W), .SEAT_H(SEAT_H),
    .SEAT_SP(SEAT_SP), .ROW_GAP(ROW_GAP), .SPR_W(SPR_W), .SPR_H(SPR_H)
  ) u_decode (
    .hCount   (hCount),
    .vCount   (vCount),
    .occupied (occupied),
    .any_hit  (any_hit),
    .winner   (winner),
    .rom_row  (rom_row),
    .rom_col  (rom_col)
  );

  assign frame_end   = (hCount == 10'(H_LAST)) && (vCount == 10'(V_LAST));
  assign vld_pipe[0] = bright & any_hit;
  assign sprite_on_d = vld_pipe[STAGES];
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge ClkPort or negedge rst) begin
    if (!rst) begin
      vld_pipe[STAGES:1] <= '0;
      seat_idx_d         <= '0;
      frame_tick         <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      seat_idx_d         <= winner;
      frame_tick         <= frame_end;
    end
  end

  always_ff @(posedge ClkPort or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      occupied <= '0;
      pending  <= '0;
      fcnt     <= '0;
    end else begin
      state    <= state_n;
      occupied <= occ_n;
      pending  <= pend_n;
      fcnt     <= fcnt_n;
    end
  end

  // occupied only moves in a frame_tick cycle, so a frame never tears.
  // A tick coinciding with acceptance is consumed in IDLE and not counted.
  always_comb begin
    state_n = state;
    occ_n   = occupied;
    pend_n  = pending;
    fcnt_n  = fcnt;
    unique case (state)
      S_IDLE: begin
        if (req.valid) begin
          fcnt_n = '0;
          case (req.op)
            OP_FILL:  state_n = S_FILL;
            OP_CLEAR: state_n = S_CLEAR;
            OP_LOAD: begin
              state_n = S_LOAD;
              pend_n  = req.mask;
            end
            default: ;
          endcase
        end
      end
      S_FILL, S_CLEAR: begin
        if (frame_tick) begin
          if (fcnt == STEP_LAST) begin
            fcnt_n = '0;
            if (state == S_FILL) begin
              if (occupied == '1) state_n = S_IDLE;
              else                occ_n   = set_lowest_clear(occupied);
            end else begin
              if (occupied == '0) state_n = S_IDLE;
              else                occ_n   = clear_highest_set(occupied);
            end
          end else begin
            fcnt_n = fcnt + 8'd1;
          end
        end
      end
      S_LOAD: begin
        if (frame_tick) begin
          occ_n   = pending;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seat_sprite_scheduler.sv
module tb_seat_sprite_scheduler;

  localparam int P = 2;  // FILL_PERIOD used for this bench

  logic       ClkPort = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hCount = '0;
  logic [9:0] vCount = '0;
  logic       bright = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_mask = '0;
  logic       cmd_ready, sprite_on_d, busy, frame_tick;
  logic [4:0] rom_row, rom_col;
  logic [2:0] seat_idx_d;
  logic [7:0] occupied;

  seat_sprite_scheduler #(.FILL_PERIOD(P)) dut (
    .ClkPort(ClkPort), .rst(rst), .hCount(hCount), .vCount(vCount), .bright(bright),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_ready(cmd_ready),
    .rom_row(rom_row), .rom_col(rom_col), .sprite_on_d(sprite_on_d), .seat_idx_d(seat_idx_d),
    .occupied(occupied), .busy(busy), .frame_tick(frame_tick)
  );

  always #5 ClkPort = ~ClkPort;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 fill, 2 clear, 3 load
  int         m_mode = 0;
  int         m_cnt  = 0;
  logic [7:0] m_occ  = '0;
  logic [7:0] m_pend = '0;

  function automatic int win_x(input int i);
    return 450 + (i % 4) * (40 + 15) + (40 - 30) / 2;
  endfunction

  function automatic int win_y(input int i);
    return 360 + (i / 4) * (40 + 15) + (40 - 30) / 2;
  endfunction

  function automatic void pix_ref(input int h, input int v, input logic [7:0] occ,
                                  output logic hit, output int idx, output int row, output int col);
    hit = 1'b0; idx = 0; row = 0; col = 0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && occ[i] && h >= win_x(i) && h < win_x(i) + 30 &&
          v >= win_y(i) && v < win_y(i) + 30) begin
        hit = 1'b1; idx = i; row = v - win_y(i); col = h - win_x(i);
      end
    end
  endfunction

  // One frame-end event as seen by the scheduler: fill/clear step every P ticks.
  task automatic model_tick();
    case (m_mode)
      1, 2: begin
        if (m_cnt == P - 1) begin
          m_cnt = 0;
          if (m_mode == 1) begin
            if (m_occ == 8'hFF) m_mode = 0;
            else begin
              for (int i = 0; i < 8; i++) if (!m_occ[i]) begin m_occ[i] = 1'b1; break; end
            end
          end else begin
            if (m_occ == 8'h00) m_mode = 0;
            else begin
              for (int i = 7; i >= 0; i--) if (m_occ[i]) begin m_occ[i] = 1'b0; break; end
            end
          end
        end else m_cnt++;
      end
      3: begin m_occ = m_pend; m_mode = 0; end
      default: ;
    endcase
  endtask

  task automatic cyc();
    @(posedge ClkPort); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      hCount = 10'($urandom_range(0, 798));
      vCount = 10'($urandom_range(0, 523));
      bright = 1'($urandom);
      cyc();
      n_checks++;
      if (occupied !== m_occ) begin
        n_fail++; $display("FAIL occ_midframe: got %h want %h", occupied, m_occ);
      end
      n_checks++;
      if (frame_tick !== 1'b0) begin
        n_fail++; $display("FAIL tick_midframe: got %b want 0", frame_tick);
      end
    end
  endtask

  task automatic frame();
    idle_cycles($urandom_range(1, 4));
    hCount = 10'd799; vCount = 10'd524;
    cyc();
    n_checks++;
    if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL tick_high: got %b want 1", frame_tick); end
    n_checks++;
    if (occupied !== m_occ) begin n_fail++; $display("FAIL occ_in_tick: got %h want %h", occupied, m_occ); end
    hCount = 10'd0; vCount = 10'd0;
    cyc();
    model_tick();
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_pulse: got %b want 0", frame_tick); end
    n_checks++;
    if (occupied !== m_occ) begin n_fail++; $display("FAIL occ_after_tick: got %h want %h", occupied, m_occ); end
    n_checks++;
    if (busy !== (m_mode != 0)) begin n_fail++; $display("FAIL busy_after_tick: got %b want %b", busy, m_mode != 0); end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] mask);
    hCount = 10'd0; vCount = 10'd0;
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0; cmd_op = 2'b00;
    m_cnt = 0;
    case (op)
      2'b01: m_mode = 1;
      2'b10: m_mode = 2;
      2'b11: begin m_mode = 3; m_pend = mask; end
      default: ;
    endcase
    n_checks++;
    if (busy !== (op != 2'b00)) begin n_fail++; $display("FAIL busy_on_accept: got %b want %b", busy, op != 2'b00); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_checks++;
    if (occupied !== 8'h00) begin n_fail++; $display("FAIL rst_occ: got %h want 00", occupied); end
    n_checks++;
    if ({busy, cmd_ready, sprite_on_d, frame_tick} !== 4'b0100) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0100", {busy, cmd_ready, sprite_on_d, frame_tick});
    end
    n_checks++;
    if (seat_idx_d !== 3'd0) begin n_fail++; $display("FAIL rst_idx: got %0d want 0", seat_idx_d); end
    cyc();
    rst = 1'b1;
    cyc();
    m_mode = 0; m_occ = '0; m_cnt = 0;
  endtask

  task automatic test_load();
    send_cmd(2'b11, 8'h81);
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready: got %b want 0", cmd_ready); end
    frame();
    n_checks++;
    if (occupied !== 8'h81) begin n_fail++; $display("FAIL load_occ: got %h want 81", occupied); end
    hCount = 10'(win_x(0)); vCount = 10'(win_y(0)); bright = 1'b1;
    #1;
    n_checks++;
    if ({rom_row, rom_col} !== 10'd0) begin n_fail++; $display("FAIL seat0_addr: got %0d,%0d want 0,0", rom_row, rom_col); end
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b1 || seat_idx_d !== 3'd0) begin
      n_fail++; $display("FAIL seat0_hit: got %b/%0d want 1/0", sprite_on_d, seat_idx_d);
    end
    hCount = 10'(win_x(1) + 3); vCount = 10'(win_y(1) + 3);
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b0) begin n_fail++; $display("FAIL seat1_empty: got %b want 0", sprite_on_d); end
  endtask

  task automatic test_pixels_random();
    logic hit; int idx, row, col, s, h, v;
    logic b;
    for (int m = 0; m < 4; m++) begin
      send_cmd(2'b11, (m == 0) ? 8'hFF : 8'($urandom));
      frame();
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          h = $urandom_range(0, 798); v = $urandom_range(0, 523);
        end else begin
          s = $urandom_range(0, 7);
          h = win_x(s) + $urandom_range(0, 36) - 3;
          v = win_y(s) + $urandom_range(0, 36) - 3;
        end
        b = ($urandom_range(0, 3) != 0);
        hCount = 10'(h); vCount = 10'(v); bright = b;
        pix_ref(h, v, m_occ, hit, idx, row, col);
        #1;
        n_checks++;
        if (rom_row !== 5'(row) || rom_col !== 5'(col)) begin
          n_fail++; $display("FAIL rnd_addr (%0d,%0d): got %0d,%0d want %0d,%0d", h, v, rom_row, rom_col, row, col);
        end
        cyc();
        n_checks++;
        if (sprite_on_d !== (b & hit)) begin
          n_fail++; $display("FAIL rnd_hit (%0d,%0d): got %b want %b", h, v, sprite_on_d, b & hit);
        end
        if (hit) begin
          n_checks++;
          if (seat_idx_d !== 3'(idx)) begin
            n_fail++; $display("FAIL rnd_idx (%0d,%0d): got %0d want %0d", h, v, seat_idx_d, idx);
          end
        end
      end
    end
  endtask

  task automatic test_boundary();
    send_cmd(2'b11, 8'hFF);
    frame();
    bright = 1'b1;
    hCount = 10'(win_x(0) + 29); vCount = 10'(win_y(0) + 10);
    #1;
    n_checks++;
    if (rom_col !== 5'd29 || rom_row !== 5'd10) begin n_fail++; $display("FAIL edge_x29: got %0d,%0d want 10,29", rom_row, rom_col); end
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b1) begin n_fail++; $display("FAIL edge_x29_hit: got %b want 1", sprite_on_d); end
    hCount = 10'(win_x(0) + 30);
    #1;
    n_checks++;
    if (rom_col !== 5'd0) begin n_fail++; $display("FAIL edge_x30_addr: got %0d want 0", rom_col); end
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b0) begin n_fail++; $display("FAIL edge_x30_hit: got %b want 0", sprite_on_d); end
    hCount = 10'(win_x(0) - 1);
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b0) begin n_fail++; $display("FAIL edge_xm1_hit: got %b want 0", sprite_on_d); end
    hCount = 10'(win_x(5) + 4); vCount = 10'(win_y(5) + 29);
    #1;
    n_checks++;
    if (rom_row !== 5'd29 || rom_col !== 5'd4) begin n_fail++; $display("FAIL edge_y29: got %0d,%0d want 29,4", rom_row, rom_col); end
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b1 || seat_idx_d !== 3'd5) begin n_fail++; $display("FAIL edge_y29_hit: got %b/%0d want 1/5", sprite_on_d, seat_idx_d); end
    vCount = 10'(win_y(5) + 30);
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b0) begin n_fail++; $display("FAIL edge_y30_hit: got %b want 0", sprite_on_d); end
    bright = 1'b0; hCount = 10'(win_x(2) + 5); vCount = 10'(win_y(2) + 5);
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b0) begin n_fail++; $display("FAIL dark_hit: got %b want 0", sprite_on_d); end
  endtask

  task automatic test_fill();
    int f;
    send_cmd(2'b11, 8'h00);
    frame();
    send_cmd(2'b01, 8'h00);
    f = 0;
    while (m_mode != 0 && f < 40) begin frame(); f++; end
    n_checks++;
    if (m_mode != 0) begin n_fail++; $display("FAIL fill_timeout: frames %0d", f); end
    n_checks++;
    if (occupied !== 8'hFF || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_end: got %h/%b want ff/1", occupied, cmd_ready);
    end
  endtask

  task automatic test_clear();
    int f;
    send_cmd(2'b10, 8'h00);
    f = 0;
    while (m_mode != 0 && f < 40) begin frame(); f++; end
    n_checks++;
    if (m_mode != 0) begin n_fail++; $display("FAIL clear_timeout: frames %0d", f); end
    n_checks++;
    if (occupied !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_end: got %h/%b want 00/0", occupied, busy);
    end
  endtask

  task automatic test_held_cmd();
    int f;
    logic accepted;
    send_cmd(2'b11, 8'($urandom) | 8'h20);
    frame();
    send_cmd(2'b01, 8'h00);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    accepted = 1'b0; f = 0;
    while (!(accepted && m_mode == 0) && f < 60) begin
      frame(); f++;
      if (!accepted) begin
        if (m_mode == 0) begin
          n_checks++;
          if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL held_ready: got %b want 1", cmd_ready); end
          cyc();
          cmd_valid = 1'b0; cmd_op = 2'b00;
          m_mode = 2; m_cnt = 0; accepted = 1'b1;
          n_checks++;
          if (busy !== 1'b1) begin n_fail++; $display("FAIL held_accept: got %b want 1", busy); end
        end else begin
          n_checks++;
          if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL held_blocked: got %b want 0", cmd_ready); end
        end
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (!(accepted && m_mode == 0) || occupied !== 8'h00) begin
      n_fail++; $display("FAIL held_done: occ %h accepted %b want 00/1", occupied, accepted);
    end
  endtask

  task automatic test_reset_mid_fill();
    int f;
    send_cmd(2'b01, 8'h00);
    f = 0;
    while (m_occ != 8'h07 && f < 20) begin frame(); f++; end
    n_checks++;
    if (occupied !== 8'h07 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst: got %h/%b want 07/1", occupied, busy);
    end
    hCount = 10'(win_x(0) + 5); vCount = 10'(win_y(0) + 5); bright = 1'b1;
    cyc();
    n_checks++;
    if (sprite_on_d !== 1'b1) begin n_fail++; $display("FAIL pre_rst_hit: got %b want 1", sprite_on_d); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (occupied !== 8'h00 || sprite_on_d !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: got %h/%b want 00/0", occupied, sprite_on_d);
    end
    n_checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_rst_fsm: got busy %b ready %b want 0/1", busy, cmd_ready);
    end
    cyc();
    rst = 1'b1;
    m_mode = 0; m_occ = '0; m_cnt = 0;
    cyc();
    cyc();
    n_checks++;
    if (occupied !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_rst: got %h/%b want 00/0", occupied, busy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_pixels_random();
    test_boundary();
    test_fill();
    test_clear();
    test_held_cmd();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
